// File: rtl/a5_1_pkg.sv
// a5_1_pkg: shared A5/1 register geometry, load lengths and control states.
package a5_1_pkg;
  localparam int R1_LEN = 19;
  localparam int R2_LEN = 22;
  localparam int R3_LEN = 23;
  localparam logic [R1_LEN-1:0] R1_TAPS = 19'h00027;
  localparam logic [R2_LEN-1:0] R2_TAPS = 22'h000003;
  localparam logic [R3_LEN-1:0] R3_TAPS = 23'h008007;
  localparam int R1_CLK = 10;
  localparam int R2_CLK = 11;
  localparam int R3_CLK = 12;
  localparam int KEY_LEN = 64;
  localparam int FRAME_LEN = 22;
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_KEY, S_LOAD_FRAME, S_WARMUP, S_GEN, S_HOLD, S_DRAIN
  } state_t;
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/a5_1_lfsr_core.sv
// a5_1_lfsr_core: the three A5/1 registers; ks_bit is the output bit after this cycle's step.
module a5_1_lfsr_core
  import a5_1_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic step_all,
  input  logic step_maj,
  input  logic in_bit,
  output logic ks_bit
);
  logic [R1_LEN-1:0] r1, r1_n;
  logic [R2_LEN-1:0] r2, r2_n;
  logic [R3_LEN-1:0] r3, r3_n;
  logic maj, s1, s2, s3;
  always_comb begin
    maj = maj3(r1[R1_CLK], r2[R2_CLK], r3[R3_CLK]);
    s1 = step_all || (step_maj && r1[R1_CLK] == maj);
    s2 = step_all || (step_maj && r2[R2_CLK] == maj);
    s3 = step_all || (step_maj && r3[R3_CLK] == maj);
    r1_n = s1 ? {^(r1 & R1_TAPS) ^ in_bit, r1[R1_LEN-1:1]} : r1;
    r2_n = s2 ? {^(r2 & R2_TAPS) ^ in_bit, r2[R2_LEN-1:1]} : r2;
    r3_n = s3 ? {^(r3 & R3_TAPS) ^ in_bit, r3[R3_LEN-1:1]} : r3;
    ks_bit = r1_n[0] ^ r2_n[0] ^ r3_n[0];
  end
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r1 <= '0;
      r2 <= '0;
      r3 <= '0;
    end else begin
      r1 <= r1_n;
      r2 <= r2_n;
      r3 <= r3_n;
    end
  end
endmodule

// File: rtl/a5_1_decipher.sv
// a5_1_decipher: A5/1 block decipher; keystream for the next block is generated
// while the current plaintext block waits in the single output register.
module a5_1_decipher
  import a5_1_pkg::*;
#(
  parameter int BLK_W  = 256,
  parameter int NBLK   = 256,
  parameter int WARMUP = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [63:0]      key,
  input  logic [21:0]      frame,
  output logic             busy,
  input  logic             ct_valid,
  output logic             ct_ready,
  input  logic [BLK_W-1:0] ct_data,
  output logic             pt_valid,
  input  logic             pt_ready,
  output logic [BLK_W-1:0] pt_data,
  output logic             pt_last,
  output logic             frame_done
);
  state_t state, state_n;
  logic [15:0] cnt, blk_cnt;
  logic [KEY_LEN-1:0] key_q;
  logic [FRAME_LEN-1:0] frame_q;
  logic [BLK_W-1:0] ks;
  logic accept, pt_fire, last_blk, in_bit, step_all, step_maj, ks_bit;
  assign busy = state != S_IDLE;
  assign ct_ready = state == S_HOLD && (!pt_valid || pt_ready);
  assign accept = ct_valid && ct_ready;
  assign pt_fire = pt_valid && pt_ready;
  assign last_blk = blk_cnt == 16'(NBLK - 1);
  assign step_all = state == S_LOAD_KEY || state == S_LOAD_FRAME;
  assign step_maj = state == S_WARMUP || state == S_GEN;
  assign in_bit = state == S_LOAD_KEY ? key_q[KEY_LEN-1] :
                  state == S_LOAD_FRAME ? frame_q[FRAME_LEN-1] : 1'b0;
  a5_1_lfsr_core u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state == S_IDLE),
    .step_all(step_all),
    .step_maj(step_maj),
    .in_bit  (in_bit),
    .ks_bit  (ks_bit)
  );
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:       state_n = start ? S_LOAD_KEY : S_IDLE;
      S_LOAD_KEY:   state_n = cnt == 16'(KEY_LEN - 1) ? S_LOAD_FRAME : S_LOAD_KEY;
      S_LOAD_FRAME: state_n = cnt == 16'(FRAME_LEN - 1) ? S_WARMUP : S_LOAD_FRAME;
      S_WARMUP:     state_n = cnt == 16'(WARMUP - 1) ? S_GEN : S_WARMUP;
      S_GEN:        state_n = cnt == 16'(BLK_W - 1) ? S_HOLD : S_GEN;
      S_HOLD:       state_n = !accept ? S_HOLD : last_blk ? S_DRAIN : S_GEN;
      S_DRAIN:      state_n = pt_fire ? S_IDLE : S_DRAIN;
      default:      state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt <= '0;
      blk_cnt <= '0;
      key_q <= '0;
      frame_q <= '0;
      ks <= '0;
      pt_data <= '0;
      pt_valid <= 1'b0;
      pt_last <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= state_n != state ? '0 : cnt + 16'd1;
      frame_done <= state == S_DRAIN && pt_fire;
      if (state == S_IDLE && start) begin
        key_q <= key;
        frame_q <= frame;
        blk_cnt <= '0;
      end
      if (state == S_LOAD_KEY) key_q <= key_q << 1;
      if (state == S_LOAD_FRAME) frame_q <= frame_q << 1;
      // First generated bit lands in the MSB after BLK_W shifts.
      if (state == S_GEN) ks <= {ks[BLK_W-2:0], ks_bit};
      if (accept) begin
        pt_data <= ct_data ^ ks;
        pt_valid <= 1'b1;
        pt_last <= last_blk;
        blk_cnt <= blk_cnt + 16'd1;
      end else if (pt_fire) begin
        pt_valid <= 1'b0;
        pt_last <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_a5_1_decipher.sv
// tb_a5_1_decipher: directed checks of the decipher against an independent A5/1 keystream model.
module tb_a5_1_decipher;
  localparam int NB = 4;
  localparam int LIM = 2000;
  localparam int PLAIN = 0, ZERO = 1, BP = 2, POKE = 3, ABORT = 4;
  logic clk = 1'b0;
  logic rst_n, start, ct_valid, pt_ready;
  logic [63:0] key;
  logic [21:0] frame;
  logic [255:0] ct_data;
  logic busy, ct_ready, pt_valid, pt_last, frame_done;
  logic [255:0] pt_data;
  int checks = 0;
  int failures = 0;
  logic [18:0] ma;
  logic [21:0] mb;
  logic [22:0] mc;
  always #5 clk = ~clk;
  a5_1_decipher #(.BLK_W(256), .NBLK(NB), .WARMUP(100)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key), .frame(frame), .busy(busy),
    .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data), .pt_last(pt_last),
    .frame_done(frame_done)
  );
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic m_clk(input bit all, input bit x);
    bit maj, ea, eb, ec;
    maj = (ma[10] & mb[11]) | (ma[10] & mc[12]) | (mb[11] & mc[12]);
    ea = all || ma[10] == maj;
    eb = all || mb[11] == maj;
    ec = all || mc[12] == maj;
    if (ea) ma = {ma[5] ^ ma[2] ^ ma[1] ^ ma[0] ^ x, ma[18:1]};
    if (eb) mb = {mb[1] ^ mb[0] ^ x, mb[21:1]};
    if (ec) mc = {mc[15] ^ mc[2] ^ mc[1] ^ mc[0] ^ x, mc[22:1]};
  endtask
  task automatic m_load(input logic [63:0] k, input logic [21:0] f);
    ma = '0;
    mb = '0;
    mc = '0;
    for (int i = 63; i >= 0; i--) m_clk(1'b1, k[i]);
    for (int i = 21; i >= 0; i--) m_clk(1'b1, f[i]);
    repeat (100) m_clk(1'b0, 1'b0);
  endtask
  task automatic m_block(output logic [255:0] ks);
    for (int i = 255; i >= 0; i--) begin
      m_clk(1'b0, 1'b0);
      ks[i] = ma[0] ^ mb[0] ^ mc[0];
    end
  endtask
  task automatic run_frame(input logic [63:0] k, input logic [21:0] f, input int mode);
    logic [255:0] ks, p;
    int n;
    m_load(k, f);
    key = k;
    frame = f;
    start = 1'b1;
    pt_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    key = '0;
    frame = '0;
    if (mode == POKE) begin
      repeat (200) @(negedge clk);
      start = 1'b1;
      key = ~k;
      frame = ~f;
      @(negedge clk);
      start = 1'b0;
      chk("poke_busy", busy, 1);
    end
    for (int b = 0; b < NB; b++) begin
      m_block(ks);
      for (int j = 0; j < 32; j++) p[255-8*j -: 8] = 8'(b * 32 + j);
      if (mode == ZERO) p = {32{8'hA5}};
      ct_data = mode == ZERO ? p : p ^ ks;
      ct_valid = 1'b1;
      #1;
      n = 0;
      while (!ct_ready && n < LIM) begin
        @(negedge clk);
        n++;
      end
      if (n == LIM) chk("ct_timeout", n, 0);
      if (mode == ZERO && b == 0) chk("latency", n, 442);
      if (mode == BP && b == 1) chk("bp_nobubble", n, 0);
      @(negedge clk);
      ct_valid = 1'b0;
      chk("pt_valid", pt_valid, 1);
      chk("pt_data", pt_data, p);
      chk("pt_last", pt_last, b == NB - 1);
      if (mode == ABORT && b == NB - 1) begin
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_ct_ready", ct_ready, 0);
        chk("abort_pt_valid", pt_valid, 0);
        chk("abort_pt_last", pt_last, 0);
        chk("abort_done", frame_done, 0);
        chk("abort_pt_data", pt_data, 0);
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
      if (mode == BP && b == 0) begin
        pt_ready = 1'b0;
        repeat (300) @(negedge clk);
        chk("bp_ct_ready", ct_ready, 0);
        chk("bp_hold_data", pt_data, p);
        chk("bp_hold_valid", pt_valid, 1);
        pt_ready = 1'b1;
      end
    end
    chk("done_early", frame_done, 0);
    @(negedge clk);
    chk("done_pulse", frame_done, 1);
    chk("idle_busy", busy, 0);
    chk("drained", pt_valid, 0);
    @(negedge clk);
    chk("done_once", frame_done, 0);
  endtask
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    key = '0;
    frame = '0;
    ct_valid = 1'b0;
    ct_data = '0;
    pt_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ct_ready", ct_ready, 0);
    chk("rst_pt_valid", pt_valid, 0);
    chk("rst_pt_last", pt_last, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_pt_data", pt_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(64'h0, 22'h0, ZERO);
    run_frame(64'h1223456789ABCDEF, 22'h134, PLAIN);
    run_frame(64'hDEADBEEF01234567, 22'h2AAAA, BP);
    run_frame(64'h0F1E2D3C4B5A6978, 22'h00F0F, POKE);
    run_frame(64'h1223456789ABCDEF, 22'h135, ABORT);
    run_frame(64'h1223456789ABCDEF, 22'h135, PLAIN);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/a5_1_decipher.md
Name: a5_1_decipher

Overview:
- Receive-side counterpart of the A5/1 block encryptor. Takes 256-bit ciphertext blocks and returns plaintext blocks using the identical keystream.
- Generates keystream one bit per clock into a block buffer, instead of precomputing a whole frame. Consumes ciphertext and produces plaintext over valid/ready handshakes.
- Sits between the link receiver and the message sink.
- Keystream bit order and LFSR conventions match the encryptor exactly, so cipher→decipher round-trips bit-exactly.

Parameters:
- BLK_W, 256: block width in bits; equals keystream bits generated per block.
- NBLK, 256: blocks per frame; pt_last is asserted on block NBLK-1.
- WARMUP, 100: majority-clocked cycles discarded after load.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  synchronous reset, active low.
- start  in  1  begin frame; samples key/frame; ignored unless IDLE.
- key  in  64  session key (encryptor pubk).
- frame  in  22  frame number (encryptor prik).
- busy  out  1  high in every state except IDLE.
- ct_valid  in  1  ciphertext block valid.
- ct_ready  out  1  ciphertext accept.
- ct_data  in  BLK_W  ciphertext block.
- pt_valid  out  1  plaintext valid.
- pt_ready  in  1  sink accept.
- pt_data  out  BLK_W  plaintext block.
- pt_last  out  1  qualifies final block of frame.
- frame_done  out  1  one-cycle pulse when the final block is accepted by the sink.

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; R1/R2/R3, ks buffer, and all counters cleared. busy, ct_ready, pt_valid, pt_last and frame_done are 0; pt_data is 0. Reset mid-frame aborts immediately and drops any held plaintext.
- LFSRs:
  - R1: 19 bits, feedback r1[5]^r1[2]^r1[1]^r1[0], clock bit r1[10].
  - R2: 22 bits, feedback r2[1]^r2[0], clock bit r2[11].
  - R3: 23 bits, feedback r3[15]^r3[2]^r3[1]^r3[0], clock bit r3[12].
  - A step shifts right and inserts the new bit at the MSB.
- States:
  - IDLE → LOAD_KEY on start: latch key and frame; zero the LFSRs.
  - LOAD_KEY, 64 cycles: all three registers step unconditionally. The input bit key[63] down to key[0] is XORed into each feedback.
  - LOAD_FRAME, 22 cycles: same as LOAD_KEY using frame[21] down to frame[0].
  - WARMUP, WARMUP cycles:
    - maj = majority(r1[10], r2[11], r3[12]).
    - Each register whose clock bit equals maj steps. No input bit.
  - GEN, BLK_W cycles:
    - Majority step as in WARMUP.
    - After the step, bit r1[0]^r2[0]^r3[0] is written to ks[BLK_W-1-n], where n is the generation index. The first generated bit is the MSB.
    - Then go to HOLD.
  - HOLD: ks full. ct_ready = (!pt_valid || pt_ready).
    - On ct_valid && ct_ready: pt_data <= ct_data ^ ks; pt_valid <= 1; pt_last <= (blk_cnt == NBLK-1); blk_cnt increments.
    - Next state is GEN if more blocks remain, else DRAIN.
  - DRAIN: wait for pt_valid && pt_ready on the last block, then pulse frame_done and return to IDLE.
- Overlap: keystream for block b+1 is generated while block b waits in the output register. The output register holds one block.
- ct_ready is 0 outside HOLD.
- pt_valid and pt_data stay stable until pt_ready. pt_valid clears on a pt_ready handshake unless a new block is loaded the same cycle; simultaneous drain and accept keeps pt_valid=1 with the new data.
- Latency: start at cycle 0 → ct_ready first high at cycle 64+22+WARMUP+BLK_W = 442 (defaults). Plaintext is registered 1 cycle after ct accept.
- Steady throughput: one block per BLK_W+1 cycles when the sink never stalls.
- start while busy has no effect. key and frame are don't-care after the start cycle.
- Keystream block k equals encryptor key bits [(256-k)*256-1 -: 256] for the same key/frame.

Decomposition:
- a5_1_pkg holds:
  - register lengths 19/22/23;
  - tap masks;
  - clock-bit indices 10/11/12;
  - load lengths 64/22;
  - state enum {IDLE, LOAD_KEY, LOAD_FRAME, WARMUP, GEN, HOLD, DRAIN}.
- The encryptor is to be refactored onto this package.
- Sub-module a5_1_lfsr_core: the three registers with inputs step_all, step_maj and in_bit, and output ks_bit. It is shared with the encryptor.

Test Plan:
- Zero key/frame: key=0, frame=0, start; ct=256'hA5A5…A5 held valid. Expect ct_ready at cycle 442 and pt_data == ct_data, since the keystream is all zeros.
- Round trip: key=64'h1223456789ABCDEF, frame=22'h134. Feed the encryptor's 256 output blocks produced from an incrementing-byte plaintext. Expect every pt_data to equal the original plaintext, pt_last only on block 255, and a frame_done pulse exactly once.
- Back-pressure: NBLK=4, pt_ready=0 after the first block. ct_ready must stay 0 after GEN completes, and pt_data must be stable. Release pt_ready: drain and accept happen in the same cycle with no bubble.
- Start ignored: pulse start with a different key at cycle 200. The keystream must be unchanged versus the reference model, and busy must stay 1.
- Reset mid-frame: assert rst_n=0 at block 3 while pt_valid=1. Next cycle all outputs are 0 and state is IDLE. A fresh start reproduces block 0 exactly.
- Short frame: NBLK=2, WARMUP=100. Expect exactly 2 ct handshakes, then ct_ready=0 and a frame_done pulse the cycle after the second pt handshake.
